// File: rtl/regfile_sb.sv
// Multi-port integer register file with a busy-bit scoreboard.
// It has two write ports (wp1 wins on collision) and optional same-cycle write-to-read bypass.
module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NRD*$clog2(NREGS)-1:0] ra_flat,
   output logic [NRD*XLEN-1:0]       rdata_flat,
   output logic [NRD-1:0]            rbusy,
   input  logic                      we0,
   input  logic [$clog2(NREGS)-1:0]  wa0,
   input  logic [XLEN-1:0]           wd0,
   input  logic                      we1,
   input  logic [$clog2(NREGS)-1:0]  wa1,
   input  logic [XLEN-1:0]           wd1,
   input  logic                      iss_valid,
   input  logic [$clog2(NREGS)-1:0]  iss_rd,
   input  logic                      flush,
   output logic [$clog2(NREGS):0]    busy_cnt
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  regs_r [NREGS];
   logic [NREGS-1:0] busy_r;
   logic [NREGS-1:0] busy_nxt_s;
   logic             wen0_s;
   logic             wen1_s;
   logic             iss_s;

   function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
      logic [AW:0] cnt;
      cnt = {(AW+1){1'b0}};
      for (int r = 0; r < NREGS; r++) begin
         cnt = cnt + {{AW{1'b0}}, v[r]};
      end
      return cnt;
   endfunction

   // Register 0 is hardwired when ZERO_REG is set, so writes and issues to it are masked here
   assign wen0_s = we0 && !((ZERO_REG != 0) && (wa0 == {AW{1'b0}}));
   assign wen1_s = we1 && !((ZERO_REG != 0) && (wa1 == {AW{1'b0}}));
   assign iss_s  = iss_valid && !((ZERO_REG != 0) && (iss_rd == {AW{1'b0}}));

   // Register data storage; port 1 is written last so it wins an address collision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_r[r] <= {XLEN{1'b0}};
         end
      end else begin
         if (wen0_s) regs_r[wa0] <= wd0;
         if (wen1_s) regs_r[wa1] <= wd1;
      end
   end

   // Scoreboard next state: flush dominates, then issue beats a same-cycle writeback clear
   always_comb begin
      busy_nxt_s = busy_r;
      if (flush) begin
         busy_nxt_s = {NREGS{1'b0}};
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            busy_nxt_s[r] = (iss_s && (iss_rd == AW'(r))) |
                            (busy_r[r] & ~((wen0_s && (wa0 == AW'(r))) ||
                                           (wen1_s && (wa1 == AW'(r)))));
         end
      end
   end

   // Busy bits and their registered population count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r   <= {NREGS{1'b0}};
         busy_cnt <= {(AW+1){1'b0}};
      end else begin
         busy_r   <= busy_nxt_s;
         busy_cnt <= popcount(busy_nxt_s);
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] ra_s;
      logic          zero_s;
      logic          byp0_s;
      logic          byp1_s;
      logic          iss_hit_s;

      assign ra_s      = ra_flat[i*AW +: AW];
      assign zero_s    = (ZERO_REG != 0) && (ra_s == {AW{1'b0}});
      assign byp0_s    = (BYPASS != 0) && wen0_s && (wa0 == ra_s);
      assign byp1_s    = (BYPASS != 0) && wen1_s && (wa1 == ra_s);
      assign iss_hit_s = iss_valid && (iss_rd == ra_s);

      assign rdata_flat[i*XLEN +: XLEN] = zero_s ? {XLEN{1'b0}} :
                                          byp1_s ? wd1 :
                                          byp0_s ? wd0 : regs_r[ra_s];
      // A bypassed writeback shows the register as free unless a newer producer issues now
      assign rbusy[i] = zero_s ? 1'b0 :
                        ((byp0_s || byp1_s) && !iss_hit_s) ? 1'b0 : busy_r[ra_s];
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a default instance (bypass on, 32 regs, 2 read ports) and a
// second instance (bypass off, 16 regs, 4 read ports) driven with the same writes and issues.
module tb_regfile_sb;

   logic        clk;
   logic        rst;
   logic        we0, we1, iss_valid, flush;
   logic [4:0]  wa0, wa1, iss_rd;
   logic [31:0] wd0, wd1;
   logic [4:0]  ra0, ra1;
   logic [3:0]  rb2, rb3;

   logic [9:0]   ra_a;
   logic [63:0]  rdata_a;
   logic [1:0]   rbusy_a;
   logic [5:0]   cnt_a;
   logic [15:0]  ra_b;
   logic [127:0] rdata_b;
   logic [3:0]   rbusy_b;
   logic [4:0]   cnt_b;

   int passed;
   int total;

   assign ra_a = {ra1, ra0};
   assign ra_b = {rb3, rb2, ra1[3:0], ra0[3:0]};

   regfile_sb dut_a (
      .clk(clk), .rst(rst), .ra_flat(ra_a), .rdata_flat(rdata_a), .rbusy(rbusy_a),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush), .busy_cnt(cnt_a)
   );

   regfile_sb #(.XLEN(32), .NREGS(16), .NRD(4), .ZERO_REG(1), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .ra_flat(ra_b), .rdata_flat(rdata_b), .rbusy(rbusy_b),
      .we0(we0), .wa0(wa0[3:0]), .wd0(wd0), .we1(we1), .wa1(wa1[3:0]), .wd1(wd1),
      .iss_valid(iss_valid), .iss_rd(iss_rd[3:0]), .flush(flush), .busy_cnt(cnt_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   initial begin
      passed = 0; total = 0;
      clk = 1'b0; rst = 1'b1;
      we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0; flush = 1'b0;
      wa0 = 5'd0; wa1 = 5'd0; iss_rd = 5'd0; wd0 = 32'd0; wd1 = 32'd0;
      ra0 = 5'd0; ra1 = 5'd0; rb2 = 4'd0; rb3 = 4'd0;

      // 1. reset state on every address and port
      #2;
      for (int a = 0; a < 32; a++) begin
         ra0 = 5'(a); ra1 = 5'(31 - a); rb2 = 4'(a); rb3 = 4'(15 - a);
         #1;
         check("rst_rdata_a", rdata_a, 64'd0);
         check("rst_rbusy_a", {62'd0, rbusy_a}, 64'd0);
         check("rst_rdata_b", rdata_b[63:0] | rdata_b[127:64], 64'd0);
         check("rst_rbusy_b", {60'd0, rbusy_b}, 64'd0);
      end
      check("rst_cnt_a", {58'd0, cnt_a}, 64'd0);
      check("rst_cnt_b", {59'd0, cnt_b}, 64'd0);
      rb2 = 4'd0; rb3 = 4'd0;
      @(negedge clk);
      rst = 1'b0;

      // 2. write then read same cycle
      we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra0 = 5'd5;
      #1;
      check("byp_wr_a", {32'd0, rdata_a[31:0]}, 64'h0000_0000_DEAD_BEEF);
      check("nobyp_wr_b", {32'd0, rdata_b[31:0]}, 64'd0);
      edge_wait();
      we0 = 1'b0;
      check("stored_a", {32'd0, rdata_a[31:0]}, 64'h0000_0000_DEAD_BEEF);
      check("stored_b", {32'd0, rdata_b[31:0]}, 64'h0000_0000_DEAD_BEEF);

      // 3. both ports to the same address: port 1 wins
      we0 = 1'b1; wa0 = 5'd7; wd0 = 32'd1; we1 = 1'b1; wa1 = 5'd7; wd1 = 32'd2; ra1 = 5'd7;
      #1;
      check("coll_byp_a", {32'd0, rdata_a[63:32]}, 64'd2);
      check("coll_nobyp_b", {32'd0, rdata_b[63:32]}, 64'd0);
      edge_wait();
      we0 = 1'b0; we1 = 1'b0;
      check("coll_a", {32'd0, rdata_a[63:32]}, 64'd2);
      check("coll_b", {32'd0, rdata_b[63:32]}, 64'd2);

      // 4. issue 3, issue 4, then writeback 3
      iss_valid = 1'b1; iss_rd = 5'd3; ra0 = 5'd3;
      edge_wait();
      check("cnt1_a", {58'd0, cnt_a}, 64'd1);
      check("cnt1_b", {59'd0, cnt_b}, 64'd1);
      iss_rd = 5'd4;
      edge_wait();
      iss_valid = 1'b0;
      check("cnt2_a", {58'd0, cnt_a}, 64'd2);
      check("cnt2_b", {59'd0, cnt_b}, 64'd2);
      check("busy3_a", {63'd0, rbusy_a[0]}, 64'd1);
      check("busy3_b", {63'd0, rbusy_b[0]}, 64'd1);
      we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h123;
      #1;
      check("wb_byp_busy_a", {63'd0, rbusy_a[0]}, 64'd0);
      check("wb_nobyp_busy_b", {63'd0, rbusy_b[0]}, 64'd1);
      edge_wait();
      we1 = 1'b0;
      check("wb_cnt_a", {58'd0, cnt_a}, 64'd1);
      check("wb_cnt_b", {59'd0, cnt_b}, 64'd1);
      check("wb_busy_b", {63'd0, rbusy_b[0]}, 64'd0);
      check("wb_data_a", {32'd0, rdata_a[31:0]}, 64'h123);

      // 5. issue beats same-cycle writeback; flush drops a same-cycle issue
      iss_valid = 1'b1; iss_rd = 5'd9; ra1 = 5'd9;
      edge_wait();
      check("cnt_9_a", {58'd0, cnt_a}, 64'd2);
      we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
      #1;
      check("iss_over_wb_a", {63'd0, rbusy_a[1]}, 64'd1);
      edge_wait();
      we0 = 1'b0; iss_valid = 1'b0;
      check("iss_wb_cnt_a", {58'd0, cnt_a}, 64'd2);
      check("iss_wb_cnt_b", {59'd0, cnt_b}, 64'd2);
      check("iss_wb_busy_b", {63'd0, rbusy_b[1]}, 64'd1);
      check("iss_wb_data_a", {32'd0, rdata_a[63:32]}, 64'h99);
      flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd10; we1 = 1'b1; wa1 = 5'd10; wd1 = 32'hAA;
      edge_wait();
      flush = 1'b0; iss_valid = 1'b0; we1 = 1'b0; ra0 = 5'd10;
      #1;
      check("flush_cnt_a", {58'd0, cnt_a}, 64'd0);
      check("flush_cnt_b", {59'd0, cnt_b}, 64'd0);
      check("flush_busy_a", {62'd0, rbusy_a}, 64'd0);
      check("flush_data_a", {32'd0, rdata_a[31:0]}, 64'hAA);
      check("flush_data_b", {32'd0, rdata_b[31:0]}, 64'hAA);

      // 6. register 0 ignores writes and issues
      iss_valid = 1'b1; iss_rd = 5'd4;
      edge_wait();
      we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; iss_rd = 5'd0; ra0 = 5'd0; ra1 = 5'd0;
      #1;
      check("z_rdata_a", rdata_a, 64'd0);
      check("z_rbusy_a", {62'd0, rbusy_a}, 64'd0);
      edge_wait();
      we0 = 1'b0; iss_valid = 1'b0;
      check("z_cnt_a", {58'd0, cnt_a}, 64'd1);
      check("z_cnt_b", {59'd0, cnt_b}, 64'd1);
      check("z_rdata_a2", rdata_a, 64'd0);
      check("z_rdata_b", rdata_b[63:0] | rdata_b[127:64], 64'd0);
      check("z_rbusy_b", {60'd0, rbusy_b}, 64'd0);

      // 1b. asynchronous reset mid-run, then first edge after release
      ra0 = 5'd5; ra1 = 5'd4;
      #1;
      check("pre_rst_data_a", {32'd0, rdata_a[31:0]}, 64'h0000_0000_DEAD_BEEF);
      check("pre_rst_busy_a", {63'd0, rbusy_a[1]}, 64'd1);
      #1;
      rst = 1'b1;
      #1;
      check("arst_data_a", rdata_a, 64'd0);
      check("arst_busy_a", {62'd0, rbusy_a}, 64'd0);
      check("arst_cnt_a", {58'd0, cnt_a}, 64'd0);
      check("arst_data_b", rdata_b[63:0], 64'd0);
      check("arst_cnt_b", {59'd0, cnt_b}, 64'd0);
      @(negedge clk);
      rst = 1'b0; iss_valid = 1'b1; iss_rd = 5'd3;
      edge_wait();
      iss_valid = 1'b0;
      check("post_rst_cnt_a", {58'd0, cnt_a}, 64'd1);
      check("post_rst_cnt_b", {59'd0, cnt_b}, 64'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
